// File: rtl/lc_sub_if.sv
// Operand/result bundle for the lc_sub adder/subtractor.
// The master drives operands and mode; the slave returns the registered result.
interface lc_sub_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] res;
    logic       cout;

    modport master (
        output a,
        output b,
        output cin,
        input  res,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output res,
        output cout
    );
endinterface

// File: rtl/lc_sub.sv
// 4-bit carry-lookahead adder/subtractor with a registered result.
// cin=1 computes a - b (a + ~b + 1), cin=0 computes a + b; outputs appear one cycle later.
module lc_sub (
    input  logic     clk,
    input  logic     rst,
    lc_sub_if.slave  bus
);

    logic [3:0] bx;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] s;
    logic       c0, c1, c2, c3, c4;
    logic       grp_p;
    logic       grp_g;

    logic [3:0] res_d, res_q;
    logic       cout_d, cout_q;

    // Operand conditioning: invert b when subtracting; cin doubles as carry-in.
    assign bx = bus.b ^ {4{bus.cin}};
    assign c0 = bus.cin;

    assign g = bus.a & bx;
    assign p = bus.a ^ bx;

    // Lookahead carries, each formed directly from c0 with no ripple.
    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

    // Group propagate/generate, kept for cascading wider adders.
    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign c4    = grp_g | (grp_p & c0);

    assign s = p ^ {c3, c2, c1, c0};

    always_comb begin
        res_d  = s;
        cout_d = c4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= 4'b0000;
            cout_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            cout_q <= cout_d;
        end
    end

    assign bus.res  = res_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_lc_sub.sv
// Directed and exhaustive self-checking bench for lc_sub.
module tb_lc_sub;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    lc_sub_if bus ();

    lc_sub dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands just after an edge, then wait past the next edge so outputs settle.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        apply(4'b1010, 4'b0110, 1'b0);
        checks++;
        if (bus.res !== 4'b0000 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got res=%b cout=%b, want res=0000 cout=0", bus.res, bus.cout);
        end
        rst = 1'b0;
    endtask

    // Vector layout: {a, b, cin, exp_res, exp_cout}
    task automatic test_sub_basic;
        logic [13:0] vec [3];
        vec[0] = {4'b1000, 4'b0101, 1'b1, 4'b0011, 1'b1};
        vec[1] = {4'b1111, 4'b0001, 1'b1, 4'b1110, 1'b1};
        vec[2] = {4'b1011, 4'b1001, 1'b1, 4'b0010, 1'b1};
        for (int i = 0; i < 3; i++) begin
            apply(vec[i][13:10], vec[i][9:6], vec[i][5]);
            checks++;
            if (bus.res !== vec[i][4:1] || bus.cout !== vec[i][0]) begin
                errors++;
                $display("FAIL sub_basic[%0d]: got res=%b cout=%b, want res=%b cout=%b",
                         i, bus.res, bus.cout, vec[i][4:1], vec[i][0]);
            end
        end
    endtask

    task automatic test_sub_borrow;
        logic [13:0] vec [2];
        vec[0] = {4'b0101, 4'b1011, 1'b1, 4'b1010, 1'b0};
        vec[1] = {4'b0011, 4'b0100, 1'b1, 4'b1111, 1'b0};
        for (int i = 0; i < 2; i++) begin
            apply(vec[i][13:10], vec[i][9:6], vec[i][5]);
            checks++;
            if (bus.res !== vec[i][4:1] || bus.cout !== vec[i][0]) begin
                errors++;
                $display("FAIL sub_borrow[%0d]: got res=%b cout=%b, want res=%b cout=%b",
                         i, bus.res, bus.cout, vec[i][4:1], vec[i][0]);
            end
        end
    endtask

    task automatic test_sub_equal;
        logic [13:0] vec [2];
        vec[0] = {4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1};
        vec[1] = {4'b1011, 4'b0011, 1'b1, 4'b1000, 1'b1};
        for (int i = 0; i < 2; i++) begin
            apply(vec[i][13:10], vec[i][9:6], vec[i][5]);
            checks++;
            if (bus.res !== vec[i][4:1] || bus.cout !== vec[i][0]) begin
                errors++;
                $display("FAIL sub_equal[%0d]: got res=%b cout=%b, want res=%b cout=%b",
                         i, bus.res, bus.cout, vec[i][4:1], vec[i][0]);
            end
        end
    endtask

    task automatic test_add;
        logic [13:0] vec [3];
        vec[0] = {4'b1000, 4'b0101, 1'b0, 4'b1101, 1'b0};
        vec[1] = {4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
        vec[2] = {4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1};
        for (int i = 0; i < 3; i++) begin
            apply(vec[i][13:10], vec[i][9:6], vec[i][5]);
            checks++;
            if (bus.res !== vec[i][4:1] || bus.cout !== vec[i][0]) begin
                errors++;
                $display("FAIL add[%0d]: got res=%b cout=%b, want res=%b cout=%b",
                         i, bus.res, bus.cout, vec[i][4:1], vec[i][0]);
            end
        end
    endtask

    task automatic test_hold;
        apply(4'b0110, 4'b0011, 1'b0);
        bus.a   = 4'b1111;
        bus.b   = 4'b1111;
        bus.cin = 1'b1;
        #3;
        checks++;
        if (bus.res !== 4'b1001 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL hold: got res=%b cout=%b, want res=1001 cout=0", bus.res, bus.cout);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream;
        apply(4'b0111, 4'b0001, 1'b0);
        apply(4'b1001, 4'b0100, 1'b1);
        rst = 1'b1;
        apply(4'b1111, 4'b1111, 1'b0);
        checks++;
        if (bus.res !== 4'b0000 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got res=%b cout=%b, want res=0000 cout=0", bus.res, bus.cout);
        end
        apply(4'b1110, 4'b0001, 1'b0);
        checks++;
        if (bus.res !== 4'b0000 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got res=%b cout=%b, want res=0000 cout=0", bus.res, bus.cout);
        end
        rst = 1'b0;
        apply(4'b1000, 4'b0101, 1'b1);
        checks++;
        if (bus.res !== 4'b0011 || bus.cout !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got res=%b cout=%b, want res=0011 cout=1",
                     bus.res, bus.cout);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        for (int i = 0; i < 512; i++) begin
            cin = i[8];
            a   = i[7:4];
            b   = i[3:0];
            exp = {1'b0, a} + {1'b0, b ^ {4{cin}}} + {4'b0000, cin};
            apply(a, b, cin);
            checks++;
            if ({bus.cout, bus.res} !== exp) begin
                errors++;
                $display("FAIL sweep a=%b b=%b cin=%b: got cout=%b res=%b, want cout=%b res=%b",
                         a, b, cin, bus.cout, bus.res, exp[4], exp[3:0]);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        bus.a   = 4'b0000;
        bus.b   = 4'b0000;
        bus.cin = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sub_basic();
        test_sub_borrow();
        test_sub_equal();
        test_add();
        test_hold();
        test_reset_midstream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
